// File: rtl/fifo_pkg.sv
// Shared constants and FSM encoding for the FIFO read-side consumer.
package fifo_pkg;
  localparam int FIFO_DW    = 3;
  localparam int FIFO_DEPTH = 5;
  // Wide enough to hold a lane count of PACK=8.
  localparam int LANE_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_CAP  = 2'd2
  } state_e;
endpackage

// File: rtl/fifo_pack_buf.sv
// Lane assembly buffer with flush handling and a valid/ready output register.
module fifo_pack_buf
  import fifo_pkg::*;
#(
  parameter int DW   = FIFO_DW,
  parameter int PACK = 2
) (
  input  logic                 rclk,
  input  logic                 rst,
  input  logic                 cap_i,
  input  logic [DW-1:0]        cap_data_i,
  input  logic                 busy_i,
  input  logic                 flush_i,
  input  logic                 out_ready_i,
  output logic                 full_o,
  output logic [DW*PACK-1:0]   out_data_o,
  output logic [LANE_W-1:0]    out_lanes_o,
  output logic                 out_valid_o
);
  logic [LANE_W-1:0]  lane_q, lane_d, lane_post;
  logic               flush_pend_q, flush_pend_d;
  logic [DW*PACK-1:0] out_data_q, out_data_d;
  logic [LANE_W-1:0]  out_lanes_q, out_lanes_d;
  logic               out_valid_q, out_valid_d;
  logic [DW*PACK-1:0] packed_post;
  logic               flush_now, complete, can_load, xfer;

  // Lane index as it stands once this cycle's capture (if any) is applied.
  assign lane_post = lane_q + LANE_W'(cap_i);
  assign complete  = (lane_post == LANE_W'(PACK));
  assign flush_now = flush_i | flush_pend_q;
  assign can_load  = !out_valid_q || out_ready_i;
  assign xfer      = can_load && (complete || (flush_now && lane_post != '0));
  assign full_o    = (lane_q == LANE_W'(PACK));

  genvar gi;
  generate
    for (gi = 0; gi < PACK; gi++) begin : g_lane
      logic [DW-1:0] word_q, word_post;

      assign word_post = (cap_i && lane_q == LANE_W'(gi)) ? cap_data_i : word_q;
      assign packed_post[gi*DW +: DW] = word_post;

      always_ff @(posedge rclk) begin
        if (rst || xfer) begin
          word_q <= '0;
        end else begin
          word_q <= word_post;
        end
      end
    end
  endgenerate

  always_comb begin
    lane_d       = lane_post;
    flush_pend_d = 1'b0;
    out_data_d   = out_data_q;
    out_lanes_d  = out_lanes_q;
    out_valid_d  = out_valid_q && !out_ready_i;
    if (xfer) begin
      lane_d      = '0;
      out_data_d  = packed_post;
      out_lanes_d = lane_post;
      out_valid_d = 1'b1;
    end else if (flush_now && (lane_post != '0 || busy_i)) begin
      // Keep the request alive until data exists to emit; a flush with
      // nothing buffered and no pop in flight is dropped.
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      lane_q       <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_lanes_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_lanes_q  <= out_lanes_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_lanes_o = out_lanes_q;
  assign out_valid_o = out_valid_q;
endmodule

// File: rtl/fifo_reader.sv
// FIFO read-side consumer: one-at-a-time pop FSM feeding a lane packer.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DW   = FIFO_DW,
  parameter int PACK = 2,
  parameter int CW   = 8
) (
  input  logic                rclk,
  input  logic                rst,
  input  logic                empy,
  input  logic [DW-1:0]       datout,
  output logic                rd,
  input  logic                flush,
  output logic [DW*PACK-1:0]  out_data,
  output logic [3:0]          out_lanes,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       words_rd
);
  state_e          state_q, state_d;
  logic            rd_q, rd_d;
  logic [CW-1:0]   words_q, words_d;
  logic            cap, busy, buf_full;
  logic [LANE_W-1:0] lanes;

  assign busy = (state_q != ST_IDLE);

  // POP holds rd high for the edge at which the FIFO advances datout;
  // CAP samples the settled data, so empy is only re-read once per pop.
  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empy && !buf_full) begin
          rd_d    = 1'b1;
          state_d = ST_POP;
        end
      end
      ST_POP:  state_d = ST_CAP;
      ST_CAP: begin
        cap     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign words_d = words_q + CW'(cap);

  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      words_q <= words_d;
    end
  end

  fifo_pack_buf #(
    .DW   (DW),
    .PACK (PACK)
  ) u_pack_buf (
    .rclk        (rclk),
    .rst         (rst),
    .cap_i       (cap),
    .cap_data_i  (datout),
    .busy_i      (busy),
    .flush_i     (flush),
    .out_ready_i (out_ready),
    .full_o      (buf_full),
    .out_data_o  (out_data),
    .out_lanes_o (lanes),
    .out_valid_o (out_valid)
  );

  assign out_lanes = lanes;
  assign rd        = rd_q;
  assign words_rd  = words_q;
endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Read-side consumer for the 5-deep, 3-bit FIFO. Pops words through the FIFO's rd/datout/empy interface and packs PACK consecutive words into one wide output word.
- Presents the packed word on a valid/ready handshake to downstream logic.
- Sits on the FIFO's read clock domain and is the only agent driving FIFO rd.

Parameters:
- DW, 3, width of one FIFO word; must match the FIFO datout width.
- PACK, 2, FIFO words per output word; legal range 1..8.
- CW, 8, width of the popped-word counter.

Ports:
- rclk  in  1  read-side clock; single clock for the whole block.
- rst  in  1  synchronous, active-high reset, sampled on rising rclk.
- empy  in  1  FIFO empty flag; 1 = no word available.
- datout  in  DW  FIFO read data; updated by the FIFO on the rclk edge at which it samples rd=1.
- rd  out  1  registered pop strobe to the FIFO; at most one cycle high per pop.
- flush  in  1  single-cycle request to emit a partially filled word.
- out_data  out  DW*PACK  packed word; lane 0 (LSBs) holds the first popped word.
- out_lanes  out  4  number of valid lanes in out_data (1..PACK).
- out_valid  out  1  out_data/out_lanes valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready at a rising rclk.
- words_rd  out  CW  count of captured FIFO words; wraps modulo 2^CW.

Behaviour:
- Reset (rst=1 at an edge): rd=0, out_valid=0, out_data=0, out_lanes=0, words_rd=0, assembly buffer cleared, lane index=0, FSM=IDLE.
- FSM states: IDLE, POP, CAP.
  - IDLE: if !empy and the assembly buffer is not complete, register rd=1 and go to POP. Otherwise stay.
  - POP: rd is high this cycle. At the next edge the FIFO updates datout. Register rd=0 and go to CAP.
  - CAP: at the edge leaving CAP:
    - write datout into lane [lane index];
    - lane index +1;
    - words_rd +1;
    - return to IDLE.
- Pop latency: rd rises 1 cycle after IDLE sees !empy; data is captured 2 edges after rd rises.
- Peak rate: one word per 3 cycles.
- Only one pop is outstanding at a time, so empy is re-sampled only after the FIFO count has settled. No back-to-back rd.
- Assembly complete when lane index == PACK.
- Transfer to output when either:
  - assembly is complete, or
  - a flush is pending and lane index > 0;
  - and in both cases, out_valid==0 or (out_valid && out_ready) in the same cycle.
- On transfer:
  - out_data = assembly buffer, with unused lanes zero;
  - out_lanes = lane index;
  - out_valid = 1;
  - buffer and lane index cleared.
- Transfer is permitted in the same cycle as a CAP capture. The captured word is included, and the completion check uses the post-capture lane index.
- out_valid holds, and out_data/out_lanes stay stable, until accepted. Accept without a new transfer clears out_valid at the next edge.
- Backpressure: complete buffer plus held output means IDLE does not pop. rd stays 0 even if !empy.
- flush:
  - latched as pending until a transfer occurs;
  - flush with an empty buffer (lane index 0) and no pop in flight is dropped;
  - flush during POP/CAP waits and includes the in-flight word.
- Simultaneous flush and assembly completion: one transfer, out_lanes=PACK.
- Wrap-around: words_rd rolls from 2^CW-1 to 0 with no flag. Lane index never exceeds PACK.
- Reset mid-operation: rd drops at the next edge, and any in-flight word is discarded. If the FIFO already sampled rd=1, that word is lost. This is accepted behaviour and the bench checks it.
- empy rising while in POP/CAP does not cancel the capture in progress.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_DW=3 and FIFO_DEPTH=5;
  - FSM state encoding (IDLE/POP/CAP), 2-bit;
  - lane-count width constant.
- One sub-module, fifo_pack_buf: the PACK-lane assembly buffer, lane index, completion and flush logic, and the output register with valid/ready. The top holds the pop FSM and words_rd.

Test Plan:
- Single pop: FIFO holds 3'b101, out_ready=1, PACK=2, then flush. Expect rd high exactly 1 cycle, capture 2 edges later, out_data=6'b000101, out_lanes=1, words_rd=1.
- Full packing: FIFO loaded 3'd1, 3'd2, 3'd3, 3'd4, out_ready=1. Expect two outputs, 6'b010_001 then 6'b100_011, each with out_lanes=2; words_rd=4; FIFO ends empty.
- Backpressure: 5 words queued, out_ready=0. Expect one output held stable and a second buffer completed, then rd stays 0 with !empy. Raise out_ready: the remaining word drains after one accept.
- Empty FIFO: empy=1 for 20 cycles. Expect rd never asserted, out_valid=0; a flush in this window produces no output.
- Flush coincident with a pop: flush asserted in the POP cycle. Expect the output to contain the in-flight word, out_lanes=1.
- Reset mid-pop: rst asserted in the CAP cycle. Expect rd=0, out_valid=0, words_rd=0 next cycle, and the FIFO count reduced by one (word lost).
